// File: rtl/shift_ser_frame.sv
`default_nettype none
// ============================================================================
// Module   : shift_ser_frame
// Brief    : Serial-to-parallel deserializer with a valid/ready holding
//            register, frame resync and a sticky overrun flag.
// Revision : 1.0
// ============================================================================
module shift_ser_frame #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             i_serclk,
    input  logic             i_reset,
    input  logic             i_q,
    input  logic             i_en,
    input  logic             i_start,
    input  logic             i_ready,
    input  logic             i_clr_ovr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun,
    output logic [CW-1:0]    o_bitcnt
);

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_bitcnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_fresh;
    logic             w_complete;
    logic             w_xfer;
    logic             w_load;
    logic             w_drop;

    // w_fresh is the register image when a resync takes the current bit as bit 0
    if (MSB_FIRST) begin : g_msb_first
        assign w_shifted = {r_sr[WIDTH-2:0], i_q};
        assign w_fresh   = {{(WIDTH-1){1'b0}}, i_q};
    end else begin : g_lsb_first
        assign w_shifted = {i_q, r_sr[WIDTH-1:1]};
        assign w_fresh   = {i_q, {(WIDTH-1){1'b0}}};
    end

    assign w_complete = i_en && !i_start && (r_bitcnt == C_LAST);
    assign w_xfer     = r_valid && i_ready;
    assign w_load     = w_complete && (!r_valid || i_ready);
    assign w_drop     = w_complete && r_valid && !i_ready;

    always_ff @(posedge i_serclk) begin
        if (i_reset) begin
            r_sr     <= '0;
            r_bitcnt <= '0;
        end else if (i_start) begin
            r_sr     <= i_en ? w_fresh : '0;
            r_bitcnt <= i_en ? C_ONE : '0;
        end else if (i_en) begin
            r_sr     <= w_shifted;
            r_bitcnt <= (r_bitcnt == C_LAST) ? '0 : r_bitcnt + C_ONE;
        end
    end

    // A completing word always leaves o_valid set: either it loads or the old one is kept
    always_ff @(posedge i_serclk) begin
        if (i_reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= w_shifted;
            end
            if (w_complete) begin
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
    assign o_bitcnt  = r_bitcnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_ser_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_ser_frame
// Brief    : Directed self-checking bench; MSB-first and LSB-first instances
//            share all stimulus.
// Revision : 1.0
// ============================================================================
module tb_shift_ser_frame;

    logic       clk;
    logic       reset;
    logic       q;
    logic       en;
    logic       start;
    logic       ready;
    logic       clr_ovr;
    logic [7:0] m_data,  l_data;
    logic       m_valid, l_valid;
    logic       m_ovr,   l_ovr;
    logic [3:0] m_cnt,   l_cnt;

    int checks;
    int errors;

    shift_ser_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .i_serclk (clk),
        .i_reset  (reset),
        .i_q      (q),
        .i_en     (en),
        .i_start  (start),
        .i_ready  (ready),
        .i_clr_ovr(clr_ovr),
        .o_data   (m_data),
        .o_valid  (m_valid),
        .o_overrun(m_ovr),
        .o_bitcnt (m_cnt)
    );

    shift_ser_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .i_serclk (clk),
        .i_reset  (reset),
        .i_q      (q),
        .i_en     (en),
        .i_start  (start),
        .i_ready  (ready),
        .i_clr_ovr(clr_ovr),
        .o_data   (l_data),
        .o_valid  (l_valid),
        .o_overrun(l_ovr),
        .o_bitcnt (l_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Sends v[n-1] first, down to v[0], on consecutive cycles
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            en = 1'b1;
            q  = v[i];
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        q  = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_data, m_valid, m_ovr, m_cnt} !== 14'd0) begin
            errors++;
            $display("FAIL reset_msb: data=%h valid=%b ovr=%b cnt=%0d, required all 0", m_data, m_valid, m_ovr, m_cnt);
        end
        checks++;
        if ({l_data, l_valid, l_ovr, l_cnt} !== 14'd0) begin
            errors++;
            $display("FAIL reset_lsb: data=%h valid=%b ovr=%b cnt=%0d, required all 0", l_data, l_valid, l_ovr, l_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_msb_first();
        ready = 1'b1;
        send_bits(8'hA5, 8);
        checks++;
        if ({m_valid, m_data, l_valid, l_data} !== {1'b1, 8'hA5, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL a5_word: m=%b/%h l=%b/%h, required 1/a5 1/a5", m_valid, m_data, l_valid, l_data);
        end
        checks++;
        if ({m_cnt, l_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL a5_cnt_wrap: m=%0d l=%0d, required 0 0", m_cnt, l_cnt);
        end
        @(posedge clk);
        #1;
        ready = 1'b0;
        checks++;
        if ({m_valid, l_valid} !== 2'b00) begin
            errors++;
            $display("FAIL a5_accepted: valid m=%b l=%b, required 0 0", m_valid, l_valid);
        end
    endtask

    task automatic test_bit_order();
        send_bits(8'h06, 3);
        checks++;
        if ({m_cnt, l_cnt} !== 8'h33) begin
            errors++;
            $display("FAIL partial_cnt: m=%0d l=%0d, required 3 3", m_cnt, l_cnt);
        end
        send_bits(8'h00, 5);
        checks++;
        if ({m_valid, m_data, l_valid, l_data} !== {1'b1, 8'hC0, 1'b1, 8'h03}) begin
            errors++;
            $display("FAIL bit_order: m=%b/%h l=%b/%h, required 1/c0 1/03", m_valid, m_data, l_valid, l_data);
        end
        drain();
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send_bits(8'h3C, 8);
        checks++;
        if ({m_valid, m_data, m_ovr} !== {1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL ovr_first: valid=%b data=%h ovr=%b, required 1 3c 0", m_valid, m_data, m_ovr);
        end
        send_bits(8'hC3, 8);
        checks++;
        if ({m_valid, m_data, m_ovr, l_data, l_ovr} !== {1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL ovr_drop: m=%b/%h/%b l=%h/%b, required 1/3c/1 3c/1", m_valid, m_data, m_ovr, l_data, l_ovr);
        end
        drain();
        checks++;
        if ({m_valid, m_ovr} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_sticky: valid=%b ovr=%b, required 0 1", m_valid, m_ovr);
        end
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        clr_ovr = 1'b0;
        checks++;
        if ({m_ovr, l_ovr} !== 2'b00) begin
            errors++;
            $display("FAIL ovr_clear: m=%b l=%b, required 0 0", m_ovr, l_ovr);
        end
        // second drop coincides with a clear request; the set must win
        send_bits(8'h11, 8);
        send_bits(8'h11, 7);
        en      = 1'b1;
        q       = 1'b0;
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        en      = 1'b0;
        clr_ovr = 1'b0;
        checks++;
        if ({m_ovr, m_data, l_ovr, l_data} !== {1'b1, 8'h11, 1'b1, 8'h88}) begin
            errors++;
            $display("FAIL ovr_set_wins: m=%b/%h l=%b/%h, required 1/11 1/88", m_ovr, m_data, l_ovr, l_data);
        end
        clr_ovr = 1'b1;
        drain();
        clr_ovr = 1'b0;
    endtask

    task automatic test_back_to_back();
        send_bits(8'h11, 8);
        send_bits(8'h4B, 7);
        en    = 1'b1;
        q     = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        en    = 1'b0;
        ready = 1'b0;
        checks++;
        if ({m_valid, m_data, m_ovr, l_valid, l_data, l_ovr} !== {1'b1, 8'h96, 1'b0, 1'b1, 8'h69, 1'b0}) begin
            errors++;
            $display("FAIL b2b_load: m=%b/%h/%b l=%b/%h/%b, required 1/96/0 1/69/0", m_valid, m_data, m_ovr, l_valid, l_data, l_ovr);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_data} !== {1'b1, 8'h96}) begin
            errors++;
            $display("FAIL b2b_hold: valid=%b data=%h, required 1 96", m_valid, m_data);
        end
        drain();
    endtask

    task automatic test_start();
        send_bits(8'h1F, 5);
        start = 1'b1;
        en    = 1'b1;
        q     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        en    = 1'b0;
        checks++;
        if ({m_cnt, l_cnt, m_valid} !== {4'd1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL start_cnt: m=%0d l=%0d valid=%b, required 1 1 0", m_cnt, l_cnt, m_valid);
        end
        send_bits(8'h00, 7);
        checks++;
        if ({m_valid, m_data, l_valid, l_data} !== {1'b1, 8'h80, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL start_word: m=%b/%h l=%b/%h, required 1/80 1/01", m_valid, m_data, l_valid, l_data);
        end
        send_bits(8'h05, 3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({m_cnt, m_valid, m_data, m_ovr} !== {4'd0, 1'b1, 8'h80, 1'b0}) begin
            errors++;
            $display("FAIL start_idle: cnt=%0d valid=%b data=%h ovr=%b, required 0 1 80 0", m_cnt, m_valid, m_data, m_ovr);
        end
        drain();
    endtask

    task automatic test_reset_midword();
        send_bits(8'hFF, 8);
        send_bits(8'h2A, 6);
        reset = 1'b1;
        en    = 1'b1;
        q     = 1'b1;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        q     = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        checks++;
        if ({m_data, m_valid, m_ovr, m_cnt, l_data, l_valid, l_ovr, l_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL reset_mid: m=%h/%b/%b/%0d l=%h/%b/%b/%0d, required all 0", m_data, m_valid, m_ovr, m_cnt, l_data, l_valid, l_ovr, l_cnt);
        end
        send_bits(8'h5A, 8);
        checks++;
        if ({m_valid, m_data, l_valid, l_data} !== {1'b1, 8'h5A, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL reset_then_word: m=%b/%h l=%b/%h, required 1/5a 1/5a", m_valid, m_data, l_valid, l_data);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        q       = 1'b0;
        en      = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        clr_ovr = 1'b0;
        #1;
        test_reset();
        test_msb_first();
        test_bit_order();
        test_overrun();
        test_back_to_back();
        test_start();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_ser_frame.md
SHIFT_SER_FRAME -- requirements
Module: shift_ser_frame

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in o_data[WIDTH-1]; 0 means it lands in o_data[0].
REQ-003 Derived localparam CW = clog2(WIDTH+1), the bit-counter width.
REQ-004 i_serclk  input  1  the single clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_q  input  1  serial data bit.
REQ-007 i_en  input  1  bit strobe; i_q is sampled only in cycles where i_en=1.
REQ-008 i_start  input  1  frame resync; discards any partial word.
REQ-009 i_ready  input  1  consumer accepts o_data while o_valid=1.
REQ-010 i_clr_ovr  input  1  clears o_overrun.
REQ-011 o_data  output  WIDTH  holding register carrying the last completed word.
REQ-012 o_valid  output  1  o_data holds an unaccepted word.
REQ-013 o_overrun  output  1  sticky flag: a completed word was dropped.
REQ-014 o_bitcnt  output  CW  number of bits accumulated toward the current word, 0..WIDTH-1.

Function
REQ-015 Internal shift register: MSB_FIRST=1 gives sr <= {sr[WIDTH-2:0], i_q}; MSB_FIRST=0 gives sr <= {i_q, sr[WIDTH-1:1]}; it shifts only when i_en=1.
REQ-016 o_bitcnt increments by 1 on each i_en cycle; on the WIDTH-th bit it wraps to 0 and the word completes.
REQ-017 Word completion: the holding value is the shift-register content including the current i_q bit, so output latency is 1 cycle after the final bit's i_en cycle.
REQ-018 i_start=1 with i_en=0: sr and o_bitcnt clear to 0; o_data, o_valid and o_overrun are unchanged.
REQ-019 i_start=1 with i_en=1: the partial word is discarded, the current bit is taken as bit 0 of a new word, and o_bitcnt becomes 1.
REQ-020 Handshake: a transfer occurs when o_valid=1 and i_ready=1; o_valid then clears next cycle unless a new word completes in the same cycle.
REQ-021 When completion and transfer happen in the same cycle, the new word loads into o_data and o_valid stays 1.
REQ-022 When a word completes while o_valid=1 and i_ready=0, the new word is dropped, o_data keeps the old word, and o_overrun sets to 1.
REQ-023 When a word completes while o_valid=0, it loads into o_data and o_valid sets to 1.
REQ-024 o_data changes only on a word load and is stable while o_valid=1 and i_ready=0.
REQ-025 o_overrun clears only on i_clr_ovr=1 or reset; if a set event and i_clr_ovr occur in the same cycle, the set wins.
REQ-026 i_ready while o_valid=0 has no effect.
REQ-027 o_bitcnt never exceeds WIDTH-1 for any stimulus.

Reset
REQ-028 When i_reset=1 at a rising edge: sr=0, o_bitcnt=0, o_data=0, o_valid=0, o_overrun=0.
REQ-029 Reset has priority over i_start, i_en, i_ready and i_clr_ovr; a word in progress or held is discarded.
REQ-030 The first i_en cycle after reset deasserts counts as bit 0.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, i_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive i_en cycles -> o_data=8'hA5 and o_valid=1 one cycle after the 8th bit; o_valid=0 the following cycle.
REQ-032 Same bits with MSB_FIRST=0 -> o_data=8'hA5 reversed, i.e. 8'hA5 is delivered when the bits are sent LSB-first as 1,0,1,0,0,1,0,1 (value 8'hA5).
REQ-033 i_ready=0, send 8'h3C then 8'hC3 -> o_data stays 8'h3C, o_overrun=1; then i_ready=1 for one cycle -> o_valid=0; i_clr_ovr=1 -> o_overrun=0.
REQ-034 Send 5 bits, then i_start with i_en=1 and bit 1, then 7 more bits 0 -> o_data=8'h80 (MSB_FIRST=1); o_bitcnt reads 1 after the start cycle.
REQ-035 8th bit arrives in the same cycle as i_ready=1 while an old word is held -> new word is in o_data, o_valid stays 1, o_overrun=0.
REQ-036 i_reset=1 after 6 bits with o_valid=1 -> all outputs 0 next cycle; 8 following bits form a complete word.
